// File: rtl/calc_key_sequencer.sv
// Calculator operand-entry sequencer: keypad events -> A/B/op, one-cycle ALU execute, held result.
// Optional macro CALC_CHAIN_EN: an op key in SHOW chains the held result into operand A.
module calc_key_sequencer #(
  parameter int unsigned MAX_VAL = 999999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [19:0] alu_res,
  output logic [19:0] A,
  output logic [19:0] B,
  output logic [1:0]  op,
  output logic        alu_go,
  output logic [19:0] disp_val,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam logic [23:0] MAX24 = 24'(MAX_VAL);

  state_t      cur, nxt;
  logic [19:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]  op_q, op_d;
  logic        err_q, err_d;

  logic        is_digit, is_op, is_eq, is_clr;
  logic [3:0]  op_diff;
  logic [19:0] acc_sel;
  logic [23:0] cand;
  logic        cand_ok;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = (key_code == 4'd14);
  assign is_clr   = (key_code == 4'd15);
  assign op_diff  = key_code - 4'd10;

  // Candidate is formed at 24 bits so acc*10+d never wraps before the range check.
  assign acc_sel  = (cur == ENTER_B) ? b_q : a_q;
  assign cand     = ({4'd0, acc_sel} * 24'd10) + {20'd0, key_code};
  assign cand_ok  = (cand <= MAX24);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= ENTER_A;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cur   <= nxt;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      op_q  <= op_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    nxt    = cur;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    op_d   = op_q;
    err_d  = err_q;
    alu_go = 1'b0;
    if (cur == EXEC) begin
      // Keys are dropped in this cycle; divide-by-zero is trapped here.
      alu_go = 1'b1;
      nxt    = SHOW;
      if (op_q == 2'b11 && b_q == 20'd0) begin
        res_d = '0;
        err_d = 1'b1;
      end else begin
        res_d = alu_res;
      end
    end else if (key_valid) begin
      if (is_clr) begin
        nxt   = ENTER_A;
        a_d   = '0;
        b_d   = '0;
        res_d = '0;
        op_d  = '0;
        err_d = 1'b0;
      end else begin
        case (cur)
          ENTER_A: begin
            if (is_digit) begin
              if (cand_ok) a_d = cand[19:0];
              else         err_d = 1'b1;
            end else if (is_op) begin
              op_d = op_diff[1:0];
              nxt  = OP_WAIT;
            end
          end
          OP_WAIT: begin
            if (is_digit) begin
              b_d = {16'd0, key_code};
              nxt = ENTER_B;
            end else if (is_op) begin
              op_d = op_diff[1:0];
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              if (cand_ok) b_d = cand[19:0];
              else         err_d = 1'b1;
            end else if (is_eq) begin
              nxt = EXEC;
            end
          end
          SHOW: begin
            if (is_digit) begin
              a_d = {16'd0, key_code};
              b_d = '0;
              nxt = ENTER_A;
            end else if (is_op) begin
`ifdef CALC_CHAIN_EN
              a_d  = res_q;
              b_d  = '0;
              op_d = op_diff[1:0];
              nxt  = OP_WAIT;
`else
              nxt  = SHOW;
`endif
            end
          end
          default: nxt = ENTER_A;
        endcase
      end
    end
  end

  // B stays on the display through EXEC; the result appears once it is registered.
  always_comb begin
    case (cur)
      ENTER_A, OP_WAIT: disp_val = a_q;
      ENTER_B, EXEC:    disp_val = b_q;
      SHOW:             disp_val = res_q;
      default:          disp_val = a_q;
    endcase
  end

  assign A     = a_q;
  assign B     = b_q;
  assign op    = op_q;
  assign err   = err_q;
  assign state = cur;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a behavioural ALU and a queue of expected execute results.
module tb_calc_key_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [19:0] alu_res;
  logic [19:0] a_val, b_val, disp_val;
  logic [1:0]  op;
  logic        alu_go, err;
  logic [2:0]  state;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic [1:0]  op;
    logic [19:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  calc_key_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .alu_res  (alu_res),
    .A        (a_val),
    .B        (b_val),
    .op       (op),
    .alu_go   (alu_go),
    .disp_val (disp_val),
    .err      (err),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Divide by zero returns a poison value so the sequencer's own trap is visible.
  always_comb begin
    case (op)
      2'b00:   alu_res = a_val + b_val;
      2'b01:   alu_res = a_val - b_val;
      2'b10:   alu_res = 20'(a_val * b_val);
      default: alu_res = (b_val == 20'd0) ? 20'hFFFFF : a_val / b_val;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [19:0] a, input logic [19:0] b, input logic [1:0] o,
                          input logic [19:0] r, input logic e);
    exp_t x;
    x.a = a; x.b = b; x.op = o; x.res = r; x.err = e;
    exp_q.push_back(x);
  endtask

  // Called right after the equals edge: EXEC must be live now, result one edge later.
  task automatic check_exec(input string tag);
    exp_t x;
    check_output({tag, "_alu_go_hi"}, 32'(alu_go), 32'd1);
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL %s_scoreboard: observed empty queue expected entry", tag);
      return;
    end
    x = exp_q.pop_front();
    check_output({tag, "_A"},  32'(a_val), 32'(x.a));
    check_output({tag, "_B"},  32'(b_val), 32'(x.b));
    check_output({tag, "_op"}, 32'(op),    32'(x.op));
    @(posedge clk);
    #1;
    check_output({tag, "_alu_go_lo"}, 32'(alu_go),   32'd0);
    check_output({tag, "_state"},     32'(state),    32'd4);
    check_output({tag, "_disp"},      32'(disp_val), 32'(x.res));
    check_output({tag, "_err"},       32'(err),      32'(x.err));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_A", 32'(a_val), 32'd0);
    check_output("rst_B", 32'(b_val), 32'd0);
    check_output("rst_op", 32'(op), 32'd0);
    check_output("rst_disp", 32'(disp_val), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_alu_go", 32'(alu_go), 32'd0);

    // Overflow: seventh nine is rejected and raises err.
    for (int i = 0; i < 6; i++) apply_stimulus(4'd9);
    check_output("ovf_six_A", 32'(a_val), 32'd999999);
    check_output("ovf_six_err", 32'(err), 32'd0);
    apply_stimulus(4'd9);
    check_output("ovf_A", 32'(a_val), 32'd999999);
    check_output("ovf_err", 32'(err), 32'd1);

    // Asynchronous reset mid-entry clears everything before the next edge.
    apply_stimulus(4'd15);
    apply_stimulus(4'd4);
    apply_stimulus(4'd2);
    check_output("entry_A", 32'(a_val), 32'd42);
    check_output("entry_disp", 32'(disp_val), 32'd42);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    check_output("ovf2_err", 32'(err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_A", 32'(a_val), 32'd0);
    check_output("async_disp", 32'(disp_val), 32'd0);
    check_output("async_state", 32'(state), 32'd0);
    check_output("async_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic add 12 + 34.
    apply_stimulus(4'd1);
    apply_stimulus(4'd2);
    apply_stimulus(4'd10);
    check_output("add_opwait", 32'(state), 32'd1);
    apply_stimulus(4'd3);
    apply_stimulus(4'd4);
    check_output("add_B", 32'(b_val), 32'd34);
    check_output("add_dispB", 32'(disp_val), 32'd34);
    push_exp(20'd12, 20'd34, 2'b00, 20'd46, 1'b0);
    apply_stimulus(4'd14);
    check_exec("add");

    // Divide by zero.
    apply_stimulus(4'd15);
    apply_stimulus(4'd8);
    apply_stimulus(4'd13);
    apply_stimulus(4'd0);
    push_exp(20'd8, 20'd0, 2'b11, 20'd0, 1'b1);
    apply_stimulus(4'd14);
    check_exec("div0");

    // Clear key drops err and returns to operand entry.
    apply_stimulus(4'd15);
    check_output("clr_err", 32'(err), 32'd0);
    check_output("clr_state", 32'(state), 32'd0);
    check_output("clr_disp", 32'(disp_val), 32'd0);

    // Op replacement; equals ignored in OP_WAIT.
    apply_stimulus(4'd5);
    apply_stimulus(4'd10);
    apply_stimulus(4'd11);
    apply_stimulus(4'd14);
    check_output("repl_state", 32'(state), 32'd1);
    check_output("repl_op", 32'(op), 32'd1);
    apply_stimulus(4'd2);
    push_exp(20'd5, 20'd2, 2'b01, 20'd3, 1'b0);
    apply_stimulus(4'd14);
    check_exec("sub");

    // Clear pressed in the EXEC cycle is dropped.
    apply_stimulus(4'd15);
    apply_stimulus(4'd3);
    apply_stimulus(4'd10);
    apply_stimulus(4'd4);
    apply_stimulus(4'd14);
    apply_stimulus(4'd15);
    check_output("execdrop_state", 32'(state), 32'd4);
    check_output("execdrop_disp", 32'(disp_val), 32'd7);
    check_output("execdrop_A", 32'(a_val), 32'd3);

    // Chain 6*7 then + 1.
    apply_stimulus(4'd15);
    apply_stimulus(4'd6);
    apply_stimulus(4'd12);
    apply_stimulus(4'd7);
    push_exp(20'd6, 20'd7, 2'b10, 20'd42, 1'b0);
    apply_stimulus(4'd14);
    check_exec("mul");
    apply_stimulus(4'd10);
`ifdef CALC_CHAIN_EN
    check_output("chain_state", 32'(state), 32'd1);
    check_output("chain_A", 32'(a_val), 32'd42);
    check_output("chain_op", 32'(op), 32'd0);
    apply_stimulus(4'd1);
    push_exp(20'd42, 20'd1, 2'b00, 20'd43, 1'b0);
    apply_stimulus(4'd14);
    check_exec("chain");
`else
    check_output("nochain_state", 32'(state), 32'd4);
    check_output("nochain_disp", 32'(disp_val), 32'd42);
    apply_stimulus(4'd1);
    check_output("nochain_next_state", 32'(state), 32'd0);
    check_output("nochain_A", 32'(a_val), 32'd1);
    check_output("nochain_B", 32'(b_val), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
